ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Initiator-side front end for the team's synchronous RAM macros.
- Accepts memory requests from NPORTS independent clients through valid/ready handshakes.
- Serialises them round-robin onto one RAM access port, and returns read data or a write acknowledge to the originating client.
- Sits between client engines and a single port of a 16x8 RAM, so several masters can share one physical port.

Parameters:
- NPORTS, 4, number of client request ports (2..8).
- AW, 4, RAM address width.
- DW, 8, RAM data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NPORTS  per-client request valid.
- req_ready  out  NPORTS  per-client accept; one-hot or zero.
- req_we  in  NPORTS  per-client write enable (1 = write, 0 = read).
- req_addr  in  NPORTS*AW  packed client addresses; client i at [i*AW +: AW].
- req_wdata  in  NPORTS*DW  packed client write data; client i at [i*DW +: DW].
- rsp_valid  out  NPORTS  one-cycle response strobe to the originating client.
- rsp_rdata  out  DW  response data, shared; valid only when some rsp_valid bit is set.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM registered output.
  - Valid the cycle after mem_en.
  - Write-first: on a write it returns the written data.

Behaviour:
- Reset (rst_n low, async):
  - rsp_valid = 0, rsp_rdata = 0.
  - Internal pipeline valid = 0.
  - Round-robin pointer = 0, so port 0 has highest priority.
  - req_ready and mem_* are combinational: 0 while no grant.
- Arbitration (combinational, cycle N):
  - Search req_valid starting at pointer, wrapping modulo NPORTS.
  - The first set bit wins; req_ready = onehot(winner).
  - mem_en = 1; mem_we/mem_addr/mem_wdata come from the winner's lanes.
  - No valid request: req_ready = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - The client must hold valid, we, addr and wdata stable until accepted.
  - req_ready never depends on rsp state, so there is no backpressure on responses.
  - Throughput is one accepted request per cycle.
- Pointer update: on acceptance by port k, pointer <= (k+1) mod NPORTS at the clock edge. No acceptance leaves it unchanged.
- Response pipeline:
  - Stage 1 (edge ending N): register winner index and valid flag.
  - Stage 2 (edge ending N+1): rsp_valid[winner] <= 1, rsp_rdata <= mem_rdata.
  - Latency: request accepted in cycle N, response visible in cycle N+2 for exactly one cycle.
  - Writes also respond; rsp_rdata equals the written data (write-first RAM).
- rsp_rdata holds its last value when rsp_valid = 0.
- Back-to-back: accepts in consecutive cycles produce responses in consecutive cycles, in acceptance order.
- Same-client repeat:
  - A client holding valid after acceptance competes again.
  - With other clients requesting, it waits until the pointer returns.
  - As the only requester, it wins every cycle.
- Read after write to the same address by different clients in adjacent cycles: the read sees the new data, because the RAM updates at the write edge.
- Reset mid-operation: in-flight stages are discarded, no response is emitted, and the pointer returns to 0.
- NPORTS not a power of two: the pointer wraps at NPORTS-1 -> 0 and never takes illegal values.

Decomposition:
- Shared package ram_pkg:
  - default AW/DW constants.
  - function onehot_to_idx.
  - typedef for the request record {we, addr, wdata}.
- One natural sub-module: rr_arbiter (NPORTS).
  - Ports: clk, rst_n, req vector, advance, grant one-hot.
  - Holds the pointer and priority search.
- The top level handles lane muxing and the two-stage response pipeline.

Test Plan:
- Reset, then all req_valid = 0 for 5 cycles -> mem_en = 0, req_ready = 0, rsp_valid = 0 throughout.
- Port 1 writes addr 3 = 0xA5, then port 2 reads addr 3 the next cycle -> rsp_valid[1] with rdata 0xA5 at N+2; rsp_valid[2] with rdata 0xA5 at N+3.
- All four ports hold req_valid for 8 cycles from reset -> grants in order 0,1,2,3,0,1,2,3, one per cycle, responses in the same order two cycles later.
- Grant sequence leaves the pointer at 2; then ports 0 and 3 request simultaneously -> port 3 is granted first, then port 0.
- Port 0 alone holds valid for 4 reads of addr 0..3 preloaded 0x10..0x13 -> accepted every cycle; rsp_rdata 0x10, 0x11, 0x12, 0x13 on consecutive cycles.
- rst_n pulsed low one cycle after port 2 is accepted -> no rsp_valid ever emitted for that request; next grant goes to port 0 when ports 0 and 2 request.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port arbiter: default widths, request record and
// one-hot to index conversion.
package ram_port_arbiter_pkg;

  localparam int unsigned DefAw    = 4;
  localparam int unsigned DefDw    = 8;
  localparam int unsigned MaxPorts = 8;

  typedef struct packed {
    logic             we;
    logic [DefAw-1:0] addr;
    logic [DefDw-1:0] wdata;
  } req_t;

  // Index of the set bit; returns 0 for an all-zero vector.
  function automatic logic [2:0] onehot_to_idx(input logic [MaxPorts-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxPorts; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client request/response lanes plus the single RAM access port, bundled for the arbiter.
interface ram_port_arbiter_if #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned AW     = ram_port_arbiter_pkg::DefAw,
  parameter int unsigned DW     = ram_port_arbiter_pkg::DefDw
);

  logic [NPORTS-1:0]    req_valid;
  logic [NPORTS-1:0]    req_ready;
  logic [NPORTS-1:0]    req_we;
  logic [NPORTS*AW-1:0] req_addr;
  logic [NPORTS*DW-1:0] req_wdata;
  logic [NPORTS-1:0]    rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;

  // Clients and the RAM macro side of the bus.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: priority search from a rotating pointer that moves past each winner.
module rr_arbiter #(
  parameter int unsigned NPORTS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPORTS-1:0] i_req,
  input  logic              i_advance,
  output logic [NPORTS-1:0] o_grant
);

  localparam int unsigned PtrW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_win_idx;
  logic [PtrW:0]   w_sum;
  logic            w_found;

  always_comb begin
    o_grant   = '0;
    w_win_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    for (int unsigned off = 0; off < NPORTS; off++) begin
      w_sum = {1'b0, r_ptr} + (PtrW+1)'(off);
      if (w_sum >= (PtrW+1)'(NPORTS)) w_sum = w_sum - (PtrW+1)'(NPORTS);
      if (!w_found && i_req[w_sum[PtrW-1:0]]) begin
        w_found                     = 1'b1;
        w_win_idx                   = w_sum[PtrW-1:0];
        o_grant[w_sum[PtrW-1:0]]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (w_win_idx == PtrW'(NPORTS - 1)) ? '0 : w_win_idx + PtrW'(1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises client requests round-robin onto one RAM port and routes each read data or
// write acknowledge back to its originator two cycles after acceptance.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned AW     = DefAw,
  parameter int unsigned DW     = DefDw
) (
  input logic          clk,
  input logic          rst_n,
  ram_port_arbiter_if.slave io_bus
);

  localparam int unsigned PtrW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [NPORTS-1:0] w_grant;
  logic              w_any;
  logic [PtrW-1:0]   w_sel;
  req_t              w_req;

  logic              r_s1_valid;
  logic [PtrW-1:0]   r_s1_idx;
  logic [NPORTS-1:0] r_rsp_valid;
  logic [DW-1:0]     r_rsp_rdata;

  rr_arbiter #(
    .NPORTS (NPORTS)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (io_bus.req_valid),
    .i_advance (w_any),
    .o_grant   (w_grant)
  );

  assign w_any = |w_grant;
  assign w_sel = PtrW'(onehot_to_idx(MaxPorts'(w_grant)));

  always_comb begin
    w_req = '0;
    if (w_any) begin
      w_req.we    = io_bus.req_we[w_sel];
      w_req.addr  = io_bus.req_addr[w_sel*AW +: AW];
      w_req.wdata = io_bus.req_wdata[w_sel*DW +: DW];
    end
  end

  // Ready is the grant itself: a granted request is always accepted in the same cycle.
  assign io_bus.req_ready = w_grant;
  assign io_bus.mem_en    = w_any;
  assign io_bus.mem_we    = w_req.we;
  assign io_bus.mem_addr  = w_req.addr;
  assign io_bus.mem_wdata = w_req.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_idx    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_s1_valid  <= w_any;
      r_s1_idx    <= w_sel;
      r_rsp_valid <= '0;
      if (r_s1_valid) begin
        r_rsp_valid[r_s1_idx] <= 1'b1;
        r_rsp_rdata           <= io_bus.mem_rdata;
      end
    end
  end

  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a write-first 16x8 registered RAM model.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  ram_port_arbiter_if #(.NPORTS(4), .AW(4), .DW(8)) bus ();

  ram_port_arbiter #(
    .NPORTS (4),
    .AW     (4),
    .DW     (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preloaded with 0x10+addr on the first edge, registered write-first output.
  logic [7:0] ram [16];
  bit         loaded;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'(8'h10 + i);
      loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata     <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_lane(input int p, input bit we, input logic [3:0] a, input logic [7:0] d);
    bus.req_valid[p]       = 1'b1;
    bus.req_we[p]          = we;
    bus.req_addr[p*4 +: 4] = a;
    bus.req_wdata[p*8 +: 8] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    #2;
    n_vec++;
    if (bus.rsp_valid !== 4'b0000 || bus.rsp_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_rsp: got valid=%b rdata=%h want 0000/00", bus.rsp_valid,
               bus.rsp_rdata);
    end
    n_vec++;
    if (bus.req_ready !== 4'b0000 || bus.mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_grant: got ready=%b mem_en=%b want 0000/0", bus.req_ready,
               bus.mem_en);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (bus.mem_en !== 1'b0 || bus.req_ready !== 4'b0000 || bus.rsp_valid !== 4'b0000) begin
        n_err++;
        $display("FAIL idle_c%0d: got mem_en=%b ready=%b rsp=%b want 0/0000/0000", c,
                 bus.mem_en, bus.req_ready, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_same_client();
    logic [7:0] exp_rd [4];
    exp_rd = '{8'h10, 8'h11, 8'h12, 8'h13};
    for (int c = 0; c < 7; c++) begin
      tick();
      clear_reqs();
      if (c < 4) set_lane(0, 1'b0, 4'(c), 8'h00);
      #1;
      if (c < 4) begin
        n_vec++;
        if (bus.req_ready !== 4'b0001 || bus.mem_addr !== 4'(c) || bus.mem_we !== 1'b0) begin
          n_err++;
          $display("FAIL same_grant_c%0d: got ready=%b addr=%h we=%b want 0001/%h/0", c,
                   bus.req_ready, bus.mem_addr, bus.mem_we, 4'(c));
        end
      end
      n_vec++;
      if (c >= 2 && c < 6) begin
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== exp_rd[c-2]) begin
          n_err++;
          $display("FAIL same_rsp_c%0d: got valid=%b rdata=%h want 0001/%h", c,
                   bus.rsp_valid, bus.rsp_rdata, exp_rd[c-2]);
        end
      end else if (bus.rsp_valid !== 4'b0000) begin
        n_err++;
        $display("FAIL same_norsp_c%0d: got valid=%b want 0000", c, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_raw();
    tick();
    clear_reqs();
    set_lane(1, 1'b1, 4'h3, 8'hA5);
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0010 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
        bus.mem_addr !== 4'h3 || bus.mem_wdata !== 8'hA5) begin
      n_err++;
      $display("FAIL raw_wr: got ready=%b en=%b we=%b addr=%h wdata=%h want 0010/1/1/3/a5",
               bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    clear_reqs();
    set_lane(2, 1'b0, 4'h3, 8'h00);
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0100 || bus.mem_we !== 1'b0 || bus.mem_addr !== 4'h3) begin
      n_err++;
      $display("FAIL raw_rd: got ready=%b we=%b addr=%h want 0100/0/3", bus.req_ready,
               bus.mem_we, bus.mem_addr);
    end
    tick();
    clear_reqs();
    #1;
    n_vec++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_rdata !== 8'hA5 || bus.mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL raw_wrsp: got valid=%b rdata=%h en=%b want 0010/a5/0", bus.rsp_valid,
               bus.rsp_rdata, bus.mem_en);
    end
    tick();
    n_vec++;
    if (bus.rsp_valid !== 4'b0100 || bus.rsp_rdata !== 8'hA5) begin
      n_err++;
      $display("FAIL raw_rrsp: got valid=%b rdata=%h want 0100/a5", bus.rsp_valid,
               bus.rsp_rdata);
    end
    tick();
    n_vec++;
    if (bus.rsp_valid !== 4'b0000 || bus.rsp_rdata !== 8'hA5) begin
      n_err++;
      $display("FAIL raw_hold: got valid=%b rdata=%h want 0000/a5", bus.rsp_valid,
               bus.rsp_rdata);
    end
  endtask

  task automatic test_all_ports();
    logic [3:0] exp_gnt [8];
    logic [7:0] exp_rd  [8];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_rd  = '{8'h18, 8'h19, 8'h1A, 8'h1B, 8'h18, 8'h19, 8'h1A, 8'h1B};
    tick();
    rst_n = 1'b0;
    clear_reqs();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      clear_reqs();
      if (c < 8) for (int p = 0; p < 4; p++) set_lane(p, 1'b0, 4'(8 + p), 8'h00);
      #1;
      if (c < 8) begin
        n_vec++;
        if (bus.req_ready !== exp_gnt[c]) begin
          n_err++;
          $display("FAIL all_grant_c%0d: got %b want %b", c, bus.req_ready, exp_gnt[c]);
        end
      end
      if (c >= 2) begin
        n_vec++;
        if (bus.rsp_valid !== exp_gnt[c-2] || bus.rsp_rdata !== exp_rd[c-2]) begin
          n_err++;
          $display("FAIL all_rsp_c%0d: got valid=%b rdata=%h want %b/%h", c, bus.rsp_valid,
                   bus.rsp_rdata, exp_gnt[c-2], exp_rd[c-2]);
        end
      end
    end
  endtask

  task automatic test_ptr_wrap();
    tick();
    clear_reqs();
    set_lane(1, 1'b0, 4'h9, 8'h00);
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL wrap_p1: got %b want 0010", bus.req_ready);
    end
    tick();
    clear_reqs();
    set_lane(0, 1'b0, 4'h8, 8'h00);
    set_lane(3, 1'b0, 4'hB, 8'h00);
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b1000 || bus.mem_addr !== 4'hB) begin
      n_err++;
      $display("FAIL wrap_p3: got ready=%b addr=%h want 1000/b", bus.req_ready, bus.mem_addr);
    end
    tick();
    clear_reqs();
    set_lane(0, 1'b0, 4'h8, 8'h00);
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 4'b0010 || bus.rsp_rdata !== 8'h19) begin
      n_err++;
      $display("FAIL wrap_p0: got ready=%b rsp=%b rdata=%h want 0001/0010/19", bus.req_ready,
               bus.rsp_valid, bus.rsp_rdata);
    end
    tick();
    clear_reqs();
    #1;
    n_vec++;
    if (bus.rsp_valid !== 4'b1000 || bus.rsp_rdata !== 8'h1B) begin
      n_err++;
      $display("FAIL wrap_rsp3: got valid=%b rdata=%h want 1000/1b", bus.rsp_valid,
               bus.rsp_rdata);
    end
    tick();
    n_vec++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== 8'h18) begin
      n_err++;
      $display("FAIL wrap_rsp0: got valid=%b rdata=%h want 0001/18", bus.rsp_valid,
               bus.rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    clear_reqs();
    set_lane(2, 1'b0, 4'hA, 8'h00);
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL mid_accept: got %b want 0100", bus.req_ready);
    end
    tick();
    clear_reqs();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_inrst: got %b want 0000", bus.rsp_valid);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (bus.rsp_valid !== 4'b0000 || bus.rsp_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL mid_dropped: got valid=%b rdata=%h want 0000/00", bus.rsp_valid,
               bus.rsp_rdata);
    end
    tick();
    set_lane(0, 1'b0, 4'h8, 8'h00);
    set_lane(2, 1'b0, 4'hA, 8'h00);
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_regrant: got ready=%b rsp=%b want 0001/0000", bus.req_ready,
               bus.rsp_valid);
    end
    tick();
    clear_reqs();
    tick();
    n_vec++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== 8'h18) begin
      n_err++;
      $display("FAIL mid_rsp0: got valid=%b rdata=%h want 0001/18", bus.rsp_valid,
               bus.rsp_rdata);
    end
    tick();
    n_vec++;
    if (bus.rsp_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_tail: got %b want 0000", bus.rsp_valid);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_same_client();
    test_raw();
    test_all_ports();
    test_ptr_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
